serial_subtractor: RTL

- Bit-serial subtractor: computes D = A - B - bin one bit per clock, LSB first, with a registered borrow chain.
- Inverse-direction companion to the team's ripple-carry adder datapath.
- Trades latency for area: one full-subtractor cell is reused WIDTH times.
- Sits behind a start/done handshake, so it can drop into lab datapaths driven by an FSM controller.

---
 rtl/serial_subtractor_pkg.sv | 15 +
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 101 ++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter width for a given operand width: clog2(width)+1.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake plus operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             bout;
  logic             ovf;

  modport master (
    output start, A, B, bin,
    input  busy, done, D, bout, ovf
  );

  modport slave (
    input  start, A, B, bin,
    output busy, done, D, bout, ovf
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout set on borrow.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Pure combinational difference and borrow.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - bin, one bit per clock LSB first, reusing a
// single full-subtractor cell with a registered borrow chain.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   sha_q;
  logic [WIDTH-1:0]   shb_q;
  logic               brw_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   d_q;
  logic               bout_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;

  logic               cell_d;
  logic               cell_bout;

  full_subtractor u_cell (
    .a    (sha_q[0]),
    .b    (shb_q[0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Control FSM and datapath with registered outputs; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            sha_q   <= bus.A;
            shb_q   <= bus.B;
            brw_q   <= bus.bin;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          // Difference bits enter from the MSB so bit k lands at D[k] after WIDTH shifts.
          d_q   <= {cell_d, d_q[WIDTH-1:1]};
          sha_q <= {1'b0, sha_q[WIDTH-1:1]};
          shb_q <= {1'b0, shb_q[WIDTH-1:1]};
          brw_q <= cell_bout;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // brw_q is the borrow into the MSB cell; overflow compares it with the borrow out.
            bout_q  <= cell_bout;
            ovf_q   <= brw_q ^ cell_bout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Drive the interface from the registered outputs.
  always_comb begin
    bus.busy = busy_q;
    bus.done = done_q;
    bus.D    = d_q;
    bus.bout = bout_q;
    bus.ovf  = ovf_q;
  end

endmodule
